// File: rtl/store_unit_pkg.sv
// Shared store-path definitions: funct3 width codes, FSM encoding, lane geometry.
// STORE_MISALIGN_TRAP_EN adds the FAULT state.
package store_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_LANES = DATA_W / 8;

  localparam logic [2:0] LS_B_OP = 3'b000;
  localparam logic [2:0] LS_H_OP = 3'b001;
  localparam logic [2:0] LS_W_OP = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2
`ifdef STORE_MISALIGN_TRAP_EN
    , ST_FAULT  = 2'd3
`endif
  } st_state_e;

endpackage

// File: rtl/store_unit_if.sv
// Data-memory write port: request with held address/data/enables, grant and ack back.
interface store_unit_if
  import store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_gnt;
  logic              mem_ack;

  modport master (output mem_req, mem_addr, mem_wdata, mem_be,
                  input  mem_gnt, mem_ack);
  modport slave  (input  mem_req, mem_addr, mem_wdata, mem_be,
                  output mem_gnt, mem_ack);
endinterface

// File: rtl/store_unit_lane_fmt.sv
// Combinational store lane formatter: byte enables, lane-replicated data, misalign flag.
// funct3[1:0] == 11 formats as a word; misaligned reports every illegal combination.
module store_lane_fmt
  import store_unit_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] data,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic              misaligned
);
  logic is_b, is_h, is_w;
  logic [NUM_LANES-1:0][7:0] lane_d;

  assign is_b = (funct3[1:0] == LS_B_OP[1:0]);
  assign is_h = (funct3[1:0] == LS_H_OP[1:0]);
  assign is_w = (funct3[1:0] == LS_W_OP[1:0]);

  // Each lane picks the source byte that lands on it after replication.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign be[i]     = is_b ? (addr_lo == LANE)
                     : is_h ? (addr_lo[1] == LANE[1])
                     : 1'b1;
    assign lane_d[i] = is_b ? data[7:0]
                     : is_h ? data[(i%2)*8 +: 8]
                     : data[i*8 +: 8];
  end

  assign wdata      = lane_d;
  assign misaligned = funct3[2] | (funct3[1:0] == 2'b11)
                    | (is_h & addr_lo[0])
                    | (is_w & (addr_lo != 2'b00));
endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store, issues a word-aligned memory write, reports completion.
// STORE_MISALIGN_TRAP_EN: illegal/misaligned stores fault instead of being issued.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              st_done,
  output logic              st_fault,
  store_unit_if.master      mem
);
  st_state_e         state, state_nxt;
  logic              accept;
  logic [3:0]        fmt_be;
  logic [DATA_W-1:0] fmt_wdata;
  logic              fmt_mis;

  store_lane_fmt u_fmt (
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .data       (data),
    .be         (fmt_be),
    .wdata      (fmt_wdata),
    .misaligned (fmt_mis)
  );

  assign accept = st_valid && st_ready;

  always_comb begin
    state_nxt = state;
    st_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef STORE_MISALIGN_TRAP_EN
          state_nxt = fmt_mis ? ST_FAULT : ST_REQ;
`else
          state_nxt = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (mem.mem_gnt) begin
          if (mem.mem_ack) begin
            st_done   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (mem.mem_ack) begin
          st_done   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
`ifdef STORE_MISALIGN_TRAP_EN
      ST_FAULT: state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered off the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      st_ready      <= 1'b1;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state       <= state_nxt;
      st_ready    <= (state_nxt == ST_IDLE);
      mem.mem_req <= (state_nxt == ST_REQ);
      if (state == ST_IDLE && state_nxt == ST_REQ) begin
        mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
        mem.mem_be    <= fmt_be;
        mem.mem_wdata <= fmt_wdata;
      end
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (state_nxt == ST_FAULT);
  end
  assign st_fault = fault_q;
`else
  logic fmt_mis_unused;
  assign fmt_mis_unused = fmt_mis;
  assign st_fault       = 1'b0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_unit;
`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st_valid, st_ready, st_done, st_fault;
  logic [2:0]  funct3;
  logic [31:0] addr, data;

  int total = 0;
  int bad   = 0;

  store_unit_if #(.ADDR_W(32)) mif ();

  store_unit #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .funct3   (funct3),
    .addr     (addr),
    .data     (data),
    .st_done  (st_done),
    .st_fault (st_fault),
    .mem      (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Size in bytes, offset from alignment, and the byte that lands on each lane.
  function automatic void fmt(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                              output logic [3:0] be, output logic [31:0] wd, output bit illegal);
    int n, off;
    case (f[1:0])
      2'b00:   begin n = 1; off = int'(a[1:0]);       end
      2'b01:   begin n = 2; off = int'(a[1]) * 2;     end
      default: begin n = 4; off = 0;                  end
    endcase
    be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) wd[i*8 +: 8] = d[(i % n)*8 +: 8];
    illegal = f[2] || (f[1:0] == 2'b11) || (f[1:0] == 2'b01 && a[0])
           || (f[1:0] == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // Model: at most one outstanding store, tracked as a transaction record.
  bit          m_pend, m_gnt, m_fault;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_be;

  always @(negedge clk) begin
    logic [3:0]  nbe;
    logic [31:0] nwd;
    bit          ill, e_done;
    if (!rst_n) begin
      chk("rst_ready", st_ready, 1'b1);
      chk("rst_req",   mif.mem_req, 1'b0);
      chk("rst_addr",  mif.mem_addr, 32'h0);
      chk("rst_be",    mif.mem_be, 4'h0);
      chk("rst_wdata", mif.mem_wdata, 32'h0);
      chk("rst_done",  st_done, 1'b0);
      chk("rst_fault", st_fault, 1'b0);
      m_pend = 0; m_gnt = 0; m_fault = 0;
      m_addr = '0; m_be = '0; m_wd = '0;
    end else begin
      e_done = m_pend && mif.mem_ack && (m_gnt || mif.mem_gnt);
      chk("ready", st_ready, !m_pend && !m_fault);
      chk("req",   mif.mem_req, m_pend && !m_gnt);
      chk("done",  st_done, e_done);
      chk("fault", st_fault, m_fault);
      chk("addr",  mif.mem_addr, m_addr);
      chk("be",    mif.mem_be, m_be);
      chk("wdata", mif.mem_wdata, m_wd);
      if (m_fault) m_fault = 0;
      else if (m_pend) begin
        if (e_done) m_pend = 0;
        else if (mif.mem_gnt) m_gnt = 1;
      end else if (st_valid) begin
        fmt(funct3, addr, data, nbe, nwd, ill);
        if (TRAP && ill) m_fault = 1;
        else begin
          m_pend = 1; m_gnt = 0;
          m_addr = {addr[31:2], 2'b00}; m_be = nbe; m_wd = nwd;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; funct3 = f; addr = a; data = d;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    int pos[$];
    st_valid = 0; funct3 = 0; addr = 0; data = 0;
    mif.mem_gnt = 0; mif.mem_ack = 0;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // SB at 0x1003 with gnt/ack high: done in the request cycle.
    mif.mem_gnt = 1; mif.mem_ack = 1;
    issue(3'b000, 32'h1003, 32'hAABBCCDD);
    @(negedge clk);
    chk("sb_req",   mif.mem_req, 1'b1);
    chk("sb_addr",  mif.mem_addr, 32'h1000);
    chk("sb_be",    mif.mem_be, 4'b1000);
    chk("sb_wdata", mif.mem_wdata, 32'hDDDDDDDD);
    chk("sb_done",  st_done, 1'b1);
    tick();

    // SH at 0x2002 with grant held off for 3 cycles.
    mif.mem_gnt = 0; mif.mem_ack = 0;
    issue(3'b001, 32'h2002, 32'h12345678);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mif.mem_gnt = 1;
      @(negedge clk);
      chk("sh_req",   mif.mem_req, 1'b1);
      chk("sh_be",    mif.mem_be, 4'b1100);
      chk("sh_wdata", mif.mem_wdata, 32'h56785678);
      chk("sh_ready", st_ready, 1'b0);
      tick();
    end
    mif.mem_gnt = 0; mif.mem_ack = 1;
    @(negedge clk);
    chk("sh_done",    st_done, 1'b1);
    chk("sh_waitreq", mif.mem_req, 1'b0);
    tick();
    mif.mem_ack = 0;
    @(negedge clk);
    chk("sh_ready_back", st_ready, 1'b1);

    // SW at 0x3000: grant first cycle, ack two cycles later.
    mif.mem_gnt = 1;
    issue(3'b010, 32'h3000, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_req", mif.mem_req, 1'b1);
    chk("sw_nodone", st_done, 1'b0);
    tick();
    mif.mem_gnt = 0;
    @(negedge clk);
    chk("sw_wait_req", mif.mem_req, 1'b0);
    chk("sw_wait_done", st_done, 1'b0);
    tick();
    mif.mem_ack = 1;
    @(negedge clk);
    chk("sw_done", st_done, 1'b1);
    chk("sw_wdata", mif.mem_wdata, 32'hDEADBEEF);
    tick();
    mif.mem_ack = 0;
    @(negedge clk);
    chk("sw_done_once", st_done, 1'b0);
    tick();

    // SW at 0x3002: faults with the trap, otherwise issued aligned down.
    mif.mem_gnt = 1; mif.mem_ack = 1;
    issue(3'b010, 32'h3002, 32'h01020304);
    @(negedge clk);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("mis_fault", st_fault, 1'b1);
    chk("mis_req",   mif.mem_req, 1'b0);
`else
    chk("mis_addr",  mif.mem_addr, 32'h3000);
    chk("mis_be",    mif.mem_be, 4'b1111);
`endif
    tick();
    @(negedge clk);
    chk("mis_fault_clr", st_fault, 1'b0);
    chk("mis_ready", st_ready, 1'b1);
    tick();

    // Asynchronous reset while the request is held.
    mif.mem_gnt = 0; mif.mem_ack = 0;
    issue(3'b000, 32'h5001, 32'h00000011);
    #1 chk("ar_req_before", mif.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_req",   mif.mem_req, 1'b0);
    chk("ar_ready", st_ready, 1'b1);
    chk("ar_be",    mif.mem_be, 4'h0);
    chk("ar_addr",  mif.mem_addr, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    mif.mem_gnt = 1; mif.mem_ack = 1;
    issue(3'b000, 32'h1001, 32'h0000005A);
    @(negedge clk);
    chk("ar_sb_be",    mif.mem_be, 4'b0010);
    chk("ar_sb_wdata", mif.mem_wdata, 32'h5A5A5A5A);
    chk("ar_sb_done",  st_done, 1'b1);
    tick();

    // Back-to-back SW with st_valid held high.
    st_valid = 1; funct3 = 3'b010; addr = 32'h4000; data = 32'hCAFEF00D;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (st_done) pos.push_back(c);
      tick();
    end
    st_valid = 0;
    chk("b2b_count", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("b2b_gap0", pos[1] - pos[0], 2);
      chk("b2b_gap1", pos[2] - pos[1], 2);
    end
    repeat (2) tick();

    // Randomized traffic, every funct3 value and unaligned address included.
    for (int c = 0; c < 3000; c++) begin
      st_valid    = 1'($urandom_range(0, 1));
      funct3      = 3'($urandom);
      addr        = $urandom;
      data        = $urandom;
      mif.mem_gnt = ($urandom_range(0, 9) < 6);
      mif.mem_ack = 1'($urandom_range(0, 1));
      tick();
    end
    st_valid = 0; mif.mem_gnt = 1; mif.mem_ack = 1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
